// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register file with write-back stage
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [REG_ADDR_W-1:0] CLEAR_FIRST = 5'd1;
    localparam logic [REG_ADDR_W-1:0] CLEAR_LAST  = 5'd31;

endpackage

// File: rtl/decoder5_32.sv
// decoder5_32: 5-to-32 one-hot decoder with enable
//   in  - 5-bit index
//   en  - enable; when low all outputs are zero
//   out - one-hot row select
module decoder5_32 (
    input  logic [4:0]  in,
    input  logic        en,
    output logic [31:0] out
);

    always_comb out = en ? (32'b1 << in) : '0;

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: 32-entry register file with registered write-back, forwarding and a clear sweep
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   wr_en      - write request (wr_addr, wr_data)
//   clear      - start a sweep zeroing rows 1..31
//   rd_addr_a  - read index, port A -> rd_data_a (combinational)
//   rd_addr_b  - read index, port B -> rd_data_b (combinational)
//   busy       - high while the clear sweep runs
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clear,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  busy
);

    regfile_state_t        state;
    logic [REG_ADDR_W-1:0] cnt;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] dec_in;
    logic                  dec_en;
    logic [REG_COUNT-1:0]  row_sel;
    logic [DATA_W-1:0]     load_val;
    logic [DATA_W-1:0]     regs [REG_COUNT];
    logic                  in_clear;
    logic                  accept_wr;

    always_comb in_clear = (state == CLEAR);
    always_comb accept_wr = wr_en && !clear;

    // The decoder is shared: the sweep counter drives it in CLEAR, the pending write otherwise.
    always_comb dec_in   = in_clear ? cnt : wb_addr;
    always_comb dec_en   = in_clear ? 1'b1 : wb_valid;
    always_comb load_val = in_clear ? '0 : wb_data;

    decoder5_32 u_dec (
        .in  (dec_in),
        .en  (dec_en),
        .out (row_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= CLEAR_FIRST;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (in_clear) begin
            wb_valid <= 1'b0;
            state    <= (cnt == CLEAR_LAST) ? IDLE : CLEAR;
            cnt      <= (cnt == CLEAR_LAST) ? CLEAR_FIRST : cnt + 1'b1;
        end else begin
            wb_valid <= accept_wr;
            if (accept_wr) begin
                wb_addr <= wr_addr;
                wb_data <= wr_data;
            end
            if (clear) begin
                state <= CLEAR;
                cnt   <= CLEAR_FIRST;
            end
        end
    end

    // Row 0 is never loaded, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else begin
            for (int i = 0; i < REG_COUNT; i++)
                if (row_sel[i] && i != 0) regs[i] <= load_val;
        end
    end

    always_comb rd_data_a = (rd_addr_a == '0) ? '0 :
                            (wb_valid && wb_addr == rd_addr_a) ? wb_data : regs[rd_addr_a];
    always_comb rd_data_b = (rd_addr_b == '0) ? '0 :
                            (wb_valid && wb_addr == rd_addr_b) ? wb_data : regs[rd_addr_b];

    always_comb busy = in_clear;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clear;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int busy_cycles;

    regfile_wb #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear     (clear),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr_a = a;
        rd_addr_b = a;
        #1;
        chk({tag, "_a"}, rd_data_a, exp);
        chk({tag, "_b"}, rd_data_b, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clear = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        #2 reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;

        // reset state
        chk("reset_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 32; i++) rd($sformatf("reset_r%0d", i), 5'(i), 32'd0);

        // write and forward
        wr(5'd5, 32'hDEADBEEF);
        rd_addr_a = 5'd5; rd_addr_b = 5'd6; #1;
        chk("pre_write_r5", rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0; #1;
        chk("fwd_r5", rd_data_a, 32'hDEADBEEF);
        chk("fwd_r6_b", rd_data_b, 32'd0);
        tick();
        chk("array_r5", rd_data_a, 32'hDEADBEEF);
        chk("array_r6_b", rd_data_b, 32'd0);

        // r0 protection
        wr(5'd0, 32'hFFFFFFFF);
        rd("r0_before", 5'd0, 32'd0);
        tick();
        wr_en = 1'b0;
        rd("r0_pending", 5'd0, 32'd0);
        tick();
        rd("r0_after", 5'd0, 32'd0);

        // back-to-back same index
        wr(5'd7, 32'h1);
        tick();
        rd("b2b_r7_e1", 5'd7, 32'h1);
        wr(5'd7, 32'h2);
        tick();
        wr_en = 1'b0;
        rd("b2b_r7_e2", 5'd7, 32'h2);
        tick();
        rd("b2b_r7_e3", 5'd7, 32'h2);

        // load r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i));
            tick();
        end

        // clear with simultaneous write to r3; r31 is still pending and commits at this edge
        clear = 1'b1;
        wr(5'd3, 32'hAAAA);
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        busy_cycles = busy ? 1 : 0;
        chk("clr_busy_k", {31'b0, busy}, 32'd1);
        rd("clr_r3_dropped", 5'd3, 32'd3);
        rd("clr_r31_committed", 5'd31, 32'd31);
        for (int j = 1; j <= 30; j++) begin
            if (j == 21) wr(5'd20, 32'h55);
            if (j == 25) clear = 1'b1;
            tick();
            if (busy) busy_cycles++;
            if (j == 10) begin
                rd("clr_r10_k10", 5'd10, 32'd0);
                rd("clr_r11_k10", 5'd11, 32'd11);
            end
        end
        chk("clr_busy_k30", {31'b0, busy}, 32'd1);
        tick();
        wr_en = 1'b0;
        clear = 1'b0;
        chk("clr_busy_k31", {31'b0, busy}, 32'd0);
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd31);
        for (int i = 0; i < 32; i++) rd($sformatf("clr_done_r%0d", i), 5'(i), 32'd0);

        // first write after sweep
        wr(5'd9, 32'h99);
        tick();
        wr_en = 1'b0;
        rd("post_clr_r9", 5'd9, 32'h99);
        tick();
        rd("post_clr_r9_array", 5'd9, 32'h99);

        // reset mid-clear
        wr(5'd20, 32'h20);
        tick();
        wr(5'd30, 32'h30);
        tick();
        wr_en = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (15) tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rd("mid_r15", 5'd15, 32'd0);
        rd("mid_r20", 5'd20, 32'h20);
        reset = 1'b0;
        #1;
        chk("mid_reset_busy", {31'b0, busy}, 32'd0);
        rd("mid_reset_r20", 5'd20, 32'd0);
        rd("mid_reset_r30", 5'd30, 32'd0);
        rd("mid_reset_r9", 5'd9, 32'd0);
        reset = 1'b1;
        wr(5'd4, 32'h44);
        tick();
        wr_en = 1'b0;
        rd("rel_r4_fwd", 5'd4, 32'h44);
        tick();
        rd("rel_r4_array", 5'd4, 32'h44);
        chk("rel_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

32-entry register file with a registered write-back port and a clear sequencer. It sits directly downstream of `decoder5_32`, which it instantiates to turn the 5-bit write address into one-hot row enables. A write is captured into a pending write-back stage, then committed one edge later. A forwarding path makes the pending value visible to both combinational read ports during the cycle between capture and commit. A `clear` request runs a 31-cycle sweep that zeroes registers 1..31 through the same decoder path.

## Interface
Parameters:
- `DATA_W`, default 32: register width.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low (0 = in reset).
- `wr_en`  input  1  write request, sampled at posedge.
- `wr_addr`  input  5  write register index.
- `wr_data`  input  DATA_W  write data.
- `clear`  input  1  request a zeroing sweep, sampled at posedge.
- `rd_addr_a`  input  5  read port A index.
- `rd_addr_b`  input  5  read port B index.
- `rd_data_a`  output  DATA_W  combinational read data, port A.
- `rd_data_b`  output  DATA_W  combinational read data, port B.
- `busy`  output  1  high while a clear sweep is running.

## Operation
- **Reset** (reset=0, async): all registers 0, `wb_valid`=0, state IDLE, `busy`=0, sweep counter=1.
- **Register 0:** hardwired zero. Writes to index 0 are captured but never commit. Reads of index 0 always return 0, with no forwarding.
- **States:** IDLE, CLEAR.
- **IDLE, write capture:** at posedge with `wr_en`=1 and `clear`=0, set `wb_valid`=1, `wb_addr`=`wr_addr`, `wb_data`=`wr_data`. Otherwise set `wb_valid`=0.
- **Commit:** at every posedge where `wb_valid`=1, `decoder5_32` is driven with `in`=`wb_addr`, `en`=`wb_valid`. The selected row (if ≠0) loads `wb_data`. Commit and a new capture occur at the same edge; back-to-back writes sustain one per cycle.
- **Read:**
  - If the index is 0, output 0.
  - Else if `wb_valid` and `wb_addr` equals the index, output `wb_data` (forwarding).
  - Else output the array value.
  - Both ports are evaluated independently.
- **Clear accepted:** at a posedge in IDLE with `clear`=1.
  - `clear` has priority: a `wr_en` on the same edge is discarded.
  - A pending `wb` entry still commits at that edge.
  - Next state is CLEAR; the counter is set to 1.
- **CLEAR:**
  - Each posedge the decoder is driven with `in`=counter, `en`=1, and that row loads 0; the counter then increments.
  - After the edge that clears row 31, return to IDLE. The counter does not wrap; it reloads to 1.
  - While `busy`=1, `wr_en` and `clear` are ignored and `wb_valid` stays 0.
  - Reads return current array contents: already-cleared rows read 0, the rest hold old values.
- **Mid-operation reset:** `reset` low during CLEAR or with a pending write aborts immediately to reset state. The pending write is lost.

## Timing
- **Write to read visibility:** `wr_en` sampled at edge k gives forwarded data on the read ports after edge k. The array value is valid after edge k+1.
- **Same-index writes at k and k+1:** reads after k+1 return the k+1 data.
- **Read latency:** 0 cycles (combinational from address and state).
- **Clear:** accepted at edge k; `busy`=1 from after edge k through edge k+31. Row r is zero after edge k+r. `busy`=0 after edge k+31, and the first new write can be captured at edge k+32.
- `busy` is a registered output and is glitch-free.

## Structure
- **Shared package `regfile_pkg`:**
  - `regfile_state_t` enum {IDLE, CLEAR}.
  - `REG_ADDR_W`=5.
  - `REG_COUNT`=32.
  - `CLEAR_FIRST`=1, `CLEAR_LAST`=31.
- **Sub-module:** existing `decoder5_32`, one instance. Its `in` is muxed between `wb_addr` and the sweep counter, and its `en` between `wb_valid` and the CLEAR-state indicator. The 32-bit one-hot output gates per-row loads; bit 0 is ignored.
- **Data mux:** the load value is `wb_data` in IDLE and 0 in CLEAR.
- The array and the forwarding/read logic stay in the top module.

## Test plan
- **Reset:** release reset, read all 32 indices → 0; `busy`=0.
- **Write and forward:** write 0xDEADBEEF to r5 at edge 1.
  - After edge 1: `rd_data_a` (addr 5) = 0xDEADBEEF via forwarding.
  - After edge 2: still 0xDEADBEEF from the array.
  - Port B reading r6 = 0.
- **r0 protection:** write 0xFFFFFFFF to r0, then read r0 on both ports → 0 at all times.
- **Back-to-back same index:** r7←0x1 at edge 1, r7←0x2 at edge 2 → after edge 2 read 0x2; after edge 3 read 0x2.
- **Clear sweep:** load r1..r31 with their index values, assert `clear` with a simultaneous write to r3 at edge k.
  - The write is dropped.
  - `busy` is high for exactly 31 cycles.
  - After edge k+10, r10=0 and r11=11.
  - After edge k+31, all rows are 0 and `busy`=0.
- **Reset mid-clear:** drive `reset` low at sweep step 15 → all rows 0, `busy`=0 immediately. After release, a write to r4 commits normally.
